// File: rtl/multiplexer_8to1_if.sv
// Bundle for the 8:1 lane selector: packed input lanes, select, valid qualifier
// and the combinational/registered results driven back by the selector.
interface multiplexer_8to1_if #(
    parameter int WIDTH = 1
);
    logic [8*WIDTH-1:0] i;
    logic [2:0]         s;
    logic               in_valid;
    logic [WIDTH-1:0]   out_comb;
    logic [WIDTH-1:0]   out;
    logic               out_valid;
    logic [7:0]         s_onehot;

    modport master (
        output i, s, in_valid,
        input  out_comb, out, out_valid, s_onehot
    );

    modport slave (
        input  i, s, in_valid,
        output out_comb, out, out_valid, s_onehot
    );
endinterface

// File: rtl/multiplexer_8to1.sv
// Eight-lane WIDTH-bit selector with a combinational result and an optionally
// registered, valid-qualified result carrying a one-hot echo of the select.
module multiplexer_8to1 #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    multiplexer_8to1_if.slave   bus
);

    if (WIDTH < 1) begin : g_width_check
        $error("multiplexer_8to1: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] sel_lane;
    logic [7:0]       sel_onehot;

    always_comb begin
        sel_lane   = bus.i[bus.s*WIDTH +: WIDTH];
        sel_onehot = 8'b1 << bus.s;
    end

    assign bus.out_comb = sel_lane;

    if (REGISTERED) begin : g_reg
        logic [WIDTH-1:0] out_q;
        logic             out_valid_q;
        logic [7:0]       s_onehot_q;

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; reset is asynchronous and clears all of them.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q       <= '0;
                out_valid_q <= 1'b0;
                s_onehot_q  <= 8'h00;
            end else begin
                out_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    out_q      <= sel_lane;
                    s_onehot_q <= sel_onehot;
                end
            end
        end

        assign bus.out       = out_q;
        assign bus.out_valid = out_valid_q;
        assign bus.s_onehot  = s_onehot_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign bus.out       = sel_lane;
        assign bus.out_valid = bus.in_valid;
        assign bus.s_onehot  = sel_onehot;
    end

endmodule

// File: tb/tb_multiplexer_8to1.sv
// Directed bench for multiplexer_8to1: registered WIDTH=1 instance checked
// through an expected-result queue, plus a combinational WIDTH=8 instance.
module tb_multiplexer_8to1;

    logic clk;
    logic clk_en;
    logic rst;

    multiplexer_8to1_if #(.WIDTH(1)) bus1 ();
    multiplexer_8to1_if #(.WIDTH(8)) bus8 ();

    multiplexer_8to1 #(.WIDTH(1), .REGISTERED(1'b1)) dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    multiplexer_8to1 #(.WIDTH(8), .REGISTERED(1'b0)) dut_comb (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic [7:0] out;
        logic       valid;
        logic [7:0] onehot;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;

    logic [7:0] m_out;
    logic [7:0] m_onehot;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one input beat on the registered instance and queue its result.
    task automatic drive(input logic [7:0] iv, input logic [2:0] sv, input logic v);
        exp_t e;
        bus1.i        = iv;
        bus1.s        = sv;
        bus1.in_valid = v;
        if (v) begin
            m_out    = {7'b0, iv[sv]};
            m_onehot = 8'b1 << sv;
        end
        e.out    = m_out;
        e.valid  = v;
        e.onehot = m_onehot;
        exp_q.push_back(e);
    endtask

    task automatic capture(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        check({tag, "_sb_nonempty"}, {7'b0, exp_q.size() != 0}, 8'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_out"},       {7'b0, bus1.out},       e.out);
            check({tag, "_out_valid"}, {7'b0, bus1.out_valid}, {7'b0, e.valid});
            check({tag, "_s_onehot"},  bus1.s_onehot,          e.onehot);
        end
    endtask

    initial begin
        clk_en        = 1'b0;
        rst           = 1'b0;
        m_out         = 8'h00;
        m_onehot      = 8'h00;
        bus1.i        = '0;
        bus1.s        = '0;
        bus1.in_valid = 1'b0;
        bus8.i        = '0;
        bus8.s        = '0;
        bus8.in_valid = 1'b0;

        // Reset with no clock running.
        #1 rst = 1'b1;
        #1;
        check("rst_out",       {7'b0, bus1.out},       8'h00);
        check("rst_out_valid", {7'b0, bus1.out_valid}, 8'h00);
        check("rst_s_onehot",  bus1.s_onehot,          8'h00);
        clk_en = 1'b1;
        #2 rst = 1'b0;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(8'h00, 3'd0, 1'b0);
            capture("idle");
        end

        // Walking one, back-to-back valid beats.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(8'h01 << k, 3'(k), 1'b1);
            #1 check($sformatf("walk%0d_comb", k), {7'b0, bus1.out_comb}, 8'h01);
            capture($sformatf("walk%0d", k));
        end

        // Select pointing at a zero lane.
        @(negedge clk);
        drive(8'h01, 3'd1, 1'b1);
        #1 check("mis1_comb", {7'b0, bus1.out_comb}, 8'h00);
        capture("mis1");
        @(negedge clk);
        drive(8'hFE, 3'd0, 1'b1);
        #1 check("mis2_comb", {7'b0, bus1.out_comb}, 8'h00);
        capture("mis2");

        // Capture then hold with in_valid low.
        @(negedge clk);
        drive(8'h80, 3'd7, 1'b1);
        #1 check("hold_cap_comb", {7'b0, bus1.out_comb}, 8'h01);
        capture("hold_cap");
        @(negedge clk);
        drive(8'h00, 3'd0, 1'b0);
        #1 check("hold_comb", {7'b0, bus1.out_comb}, 8'h00);
        capture("hold");

        // Async reset between edges while a valid result is showing.
        @(negedge clk);
        drive(8'h08, 3'd3, 1'b1);
        capture("pre_rst");
        @(negedge clk);
        bus1.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_out",       {7'b0, bus1.out},       8'h00);
        check("midrst_out_valid", {7'b0, bus1.out_valid}, 8'h00);
        check("midrst_s_onehot",  bus1.s_onehot,          8'h00);
        #1 rst = 1'b0;
        m_out    = 8'h00;
        m_onehot = 8'h00;
        drive(8'h00, 3'd0, 1'b0);
        capture("post_rst_idle");
        @(negedge clk);
        drive(8'h40, 3'd6, 1'b1);
        capture("post_rst_cap");

        // Combinational WIDTH=8 instance.
        for (int k = 0; k < 8; k++) bus8.i[k*8 +: 8] = 8'h10 + 8'(k);
        bus8.s        = 3'd5;
        bus8.in_valid = 1'b1;
        #1;
        check("w8_out_comb",  bus8.out_comb,          8'h15);
        check("w8_out",       bus8.out,               8'h15);
        check("w8_out_valid", {7'b0, bus8.out_valid}, 8'h01);
        check("w8_s_onehot",  bus8.s_onehot,          8'h20);
        bus8.in_valid = 1'b0;
        #1;
        check("w8_out_valid_low", {7'b0, bus8.out_valid}, 8'h00);
        bus8.s = 3'd0;
        #1;
        check("w8_sel0_out",      bus8.out,      8'h10);
        check("w8_sel0_s_onehot", bus8.s_onehot, 8'h01);

        check("sb_drained", 8'(exp_q.size()), 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
